// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: NUM_INPUTS AXI4-Stream requesters share one output.
// Latency: 1 cycle arbitration in IDLE, then a beat accepted at an edge is on out_* one cycle later.
// Backpressure: in_ready of the granted input is ~out_valid | out_ready; all others held at 0.
//
// Ports:
//   aclk, areset          - clock, synchronous active-high reset
//   in_data/last/valid    - packed requester beats (requester k at [k*DATA_WIDTH +: DATA_WIDTH])
//   in_ready              - per-requester accept, at most one bit high
//   out_data/last/id      - registered beat, end-of-packet flag and source index
//   out_valid, out_ready  - output handshake
module axis_packet_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [ID_WIDTH-1:0]              out_id,
  output logic                             out_valid,
  input  logic                             out_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [ID_WIDTH:0]   N_W      = (ID_WIDTH+1)'(NUM_INPUTS);
  localparam logic [ID_WIDTH-1:0] PTR_INIT = ID_WIDTH'(NUM_INPUTS - 1);

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   gnt_q, gnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  found;
  logic [ID_WIDTH-1:0]   pick;
  logic [ID_WIDTH:0]     scan_sum;
  logic                  sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  slot_rdy, xfer;

  // Round-robin scan starting one past the last grant; the pointer itself is
  // checked last, so a lone requester can win back-to-back.
  always_comb begin
    found    = 1'b0;
    pick     = ptr_q;
    scan_sum = '0;
    for (int i = 1; i <= NUM_INPUTS; i++) begin
      scan_sum = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
      if (scan_sum >= N_W) scan_sum = scan_sum - N_W;
      if (!found && in_valid[scan_sum[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = scan_sum[ID_WIDTH-1:0];
      end
    end
  end

  // Mux of the granted requester's beat.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (gnt_q == ID_WIDTH'(k)) begin
        sel_valid = in_valid[k];
        sel_last  = in_last[k];
        sel_data  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign slot_rdy = ~out_valid_q | out_ready;
  assign xfer     = (state_q == BUSY) & sel_valid & slot_rdy;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    in_ready    = '0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = pick;
          ptr_d   = pick;
        end
      end
      BUSY: begin
        // Gated by reset so no requester sees a grant while the FSM is being cleared.
        if (!areset) begin
          for (int k = 0; k < NUM_INPUTS; k++) begin
            if (gnt_q == ID_WIDTH'(k)) in_ready[k] = slot_rdy;
          end
        end
        if (xfer) begin
          out_valid_d = 1'b1;
          out_last_d  = sel_last;
          out_id_d    = gnt_q;
          out_data_d  = sel_data;
          if (sel_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_INIT;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
    end
  end

  // Payload is don't-care while out_valid is low, so it carries no reset.
  always_ff @(posedge aclk) begin
    out_data_q <= out_data_d;
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]  in_last = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [IW-1:0] out_id;
  logic          out_valid;
  logic          out_ready = 1'b1;

  axis_packet_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .areset(areset),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_id(out_id),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] d; logic l; int gap; } beat_t;
  typedef struct { logic [IW-1:0] id; logic l; logic [DW-1:0] d; } exp_t;

  beat_t src_q[N][$];
  exp_t  sb[$];
  int    wait_cnt[N];
  int    n_checks = 0;
  int    n_pass = 0;
  int    model_p = N - 1;
  int    ready_mode = 0;
  int    rdy_cnt = 0;
  bit    sb_en = 1'b1;
  bit    chk_gap = 1'b0;
  logic [N-1:0] hs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, req, $time);
  endtask

  // Reference model: whole packets leave in round-robin order over the
  // requesters that still have packets queued, starting after the last winner.
  function automatic void plan();
    int  pos[N];
    bit  progress;
    for (int k = 0; k < N; k++) pos[k] = 0;
    progress = 1'b1;
    while (progress) begin
      progress = 1'b0;
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (model_p + i) % N;
        if (!progress && pos[k] < src_q[k].size()) begin
          bit done;
          done = 1'b0;
          while (!done) begin
            exp_t e;
            e.id = IW'(k);
            e.l  = src_q[k][pos[k]].l;
            e.d  = src_q[k][pos[k]].d;
            sb.push_back(e);
            done = e.l;
            pos[k]++;
          end
          model_p  = k;
          progress = 1'b1;
        end
      end
    end
  endfunction

  task automatic load_pkt(input int k, input int len, input logic [DW-1:0] base,
                          input int maxgap, input int stall_at, input int stall_len);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.d   = base + DW'(b);
      x.l   = (b == len - 1);
      x.gap = (b == 0) ? 0 : (b == stall_at) ? stall_len : int'($urandom_range(maxgap, 0));
      src_q[k].push_back(x);
    end
  endtask

  // Source and sink driver: inputs change 1 time unit after each rising edge.
  always begin
    @(negedge aclk);
    hs = in_valid & in_ready;
    @(posedge aclk);
    #1;
    rdy_cnt++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1, 0));
      default: out_ready = ((rdy_cnt % 4) == 0) || ((rdy_cnt % 4) == 3);
    endcase
    for (int k = 0; k < N; k++) begin
      if (hs[k] && src_q[k].size() > 0) begin
        void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) wait_cnt[k] = src_q[k][0].gap;
      end
      if (src_q[k].size() == 0) begin
        in_valid[k] = 1'b0;
      end else if (in_valid[k] && !hs[k]) begin
        in_valid[k] = 1'b1;
      end else if (wait_cnt[k] > 0) begin
        in_valid[k] = 1'b0;
        wait_cnt[k]--;
      end else begin
        in_valid[k] = 1'b1;
        in_data[k*DW +: DW] = src_q[k][0].d;
        in_last[k] = src_q[k][0].l;
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard on every output handshake.
  logic [DW+IW:0] held;
  bit stalled = 1'b0;
  int prev_kind = 0;  // 0 none, 1 mid beat, 2 last beat, 3 bubble after last

  always @(negedge aclk) begin
    if (areset) begin
      stalled   = 1'b0;
      prev_kind = 0;
    end else begin
      chk("ready_onehot", 64'($countones(in_ready) <= 1), 64'd1);
      if (stalled) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_beat", {out_id, out_last, out_data}, held);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, '0);
        held    = {out_id, out_last, out_data};
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (!chk_gap) begin
        prev_kind = 0;
      end else begin
        if (prev_kind == 2 && sb.size() > 0) chk("gap_bubble", out_valid, 1'b0);
        else if (prev_kind == 1 || (prev_kind == 3 && sb.size() > 0)) chk("gap_stream", out_valid, 1'b1);
        prev_kind = out_valid ? (out_last ? 2 : 1) : (prev_kind == 2 ? 3 : 0);
      end
      if (sb_en && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_extra: unexpected beat id=%0d data=0x%0h at t=%0t", out_id, out_data, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_beat", {out_id, out_last, out_data}, {e.id, e.l, e.d});
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while (sb.size() > 0 && c < budget) begin
      @(posedge aclk);
      c++;
    end
    chk(name, sb.size(), 0);
    repeat (3) @(posedge aclk);
    #2;
  endtask

  initial begin
    int c;
    // Reset with every requester offering three 2-beat packets.
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 3; p++) load_pkt(k, 2, DW'((k << 8) | (p << 4)), 0, -1, 0);
    plan();
    chk_gap = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      chk("reset_in_ready", in_ready, '0);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_id", out_id, '0);
    end
    @(posedge aclk);
    #2;
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_no_ready", in_ready, '0);
    @(negedge aclk);
    chk("first_grant", in_ready, 4'b0001);
    drain("drain_rr", 400);
    chk_gap = 1'b0;

    // Source stall: requester 1 drops valid for 5 cycles mid-packet, 3 waits.
    load_pkt(1, 4, 32'h100, 0, 2, 5);
    load_pkt(3, 2, 32'h300, 0, -1, 0);
    plan();
    c = 0;
    while (!in_valid[1] && c < 50) begin @(negedge aclk); c++; end
    c = 0;
    while (in_valid[1] && c < 50) begin @(negedge aclk); c++; end
    chk("stall_seen", in_valid[1], 1'b0);
    repeat (4) begin
      chk("stall_grant", in_ready, 4'b0010);
      @(negedge aclk);
    end
    drain("drain_stall", 200);

    // Single-beat packets from 0 and 3.
    chk_gap = 1'b1;
    for (int p = 0; p < 4; p++) begin
      load_pkt(0, 1, DW'(32'h400 + p), 0, -1, 0);
      load_pkt(3, 1, DW'(32'h430 + p), 0, -1, 0);
    end
    plan();
    drain("drain_single", 200);
    chk_gap = 1'b0;

    // Backpressure with out_ready pattern 1,0,0,1.
    ready_mode = 2;
    load_pkt(2, 3, 32'hA0, 0, -1, 0);
    plan();
    drain("drain_bp", 200);
    ready_mode = 0;

    // Reset during beat 2 of a 4-beat packet from requester 1.
    sb_en = 1'b0;
    load_pkt(1, 4, 32'h500, 0, -1, 0);
    c = 0;
    while (!(in_valid[1] && in_ready[1] && in_data[DW +: DW] == 32'h501) && c < 50) begin
      @(negedge aclk);
      c++;
    end
    chk("beat2_seen", in_data[DW +: DW], 32'h501);
    @(posedge aclk);
    #2;
    areset = 1'b1;
    src_q[1].delete();
    wait_cnt[1] = 0;
    @(negedge aclk);
    chk("midreset_in_ready", in_ready, '0);
    @(posedge aclk);
    #2;
    areset  = 1'b0;
    model_p = N - 1;
    sb_en   = 1'b1;
    load_pkt(1, 1, 32'h600, 0, -1, 0);
    load_pkt(0, 1, 32'h700, 0, -1, 0);
    plan();
    @(negedge aclk);
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_out_id", out_id, '0);
    drain("drain_midreset", 200);

    // Randomized traffic with random source gaps and random out_ready.
    ready_mode = 1;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(1, 0) == 1) begin
          int np;
          np = int'($urandom_range(3, 0));
          for (int p = 0; p < np; p++)
            load_pkt(k, int'($urandom_range(4, 1)), DW'($urandom), 2, -1, 0);
        end
      end
      plan();
      drain("drain_random", 3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Round-robin, packet-granular arbiter that shares one AXI4-Stream output between NUM_INPUTS AXI4-Stream requesters. It sits upstream of the shared stream consumers, for example a DMA writer or a single input buffer stage feeding a common datapath. Grant is held from the first beat to the beat with `in_last`, so packets are never interleaved. The output is fully registered and tags every beat with the source index.

## Interface
- `NUM_INPUTS`, 4: number of requesters; legal range 2..8.
- `DATA_WIDTH`, 32: beat width in bits.
- `ID_WIDTH`, 2: width of `out_id`; must satisfy 2^ID_WIDTH >= NUM_INPUTS.
- `aclk`  in  1: single clock; all logic is on the rising edge.
- `areset`  in  1: synchronous, active-high reset.
- `in_data`  in  NUM_INPUTS*DATA_WIDTH: requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `in_last`  in  NUM_INPUTS: end-of-packet flag, one bit per requester.
- `in_valid`  in  NUM_INPUTS: beat valid, one bit per requester.
- `in_ready`  out  NUM_INPUTS: beat accepted, one bit per requester; at most one bit is high.
- `out_data`  out  DATA_WIDTH: registered beat.
- `out_last`  out  1: registered end-of-packet flag.
- `out_id`  out  ID_WIDTH: index of the requester that sourced the beat.
- `out_valid`  out  1: output beat valid.
- `out_ready`  in  1: downstream accept.

## Operation
- **FSM states:**
  - IDLE: no grant; all `in_ready` = 0.
  - BUSY: grant locked to index `g`.
- **Pointer:** round-robin pointer `p` holds the last granted index. Reset value is NUM_INPUTS-1, so input 0 has first priority.
- **Arbitration (IDLE):**
  - Scan indices p+1, p+2, … modulo NUM_INPUTS; take the first with `in_valid` high.
  - If one is found: g <= found index, p <= found index, go to BUSY.
  - If none is found: remain in IDLE.
- **BUSY:**
  - `in_ready[g]` = ~out_valid | out_ready, computed combinationally. All other `in_ready` bits are 0.
  - On a transfer (`in_valid[g]` & `in_ready[g]`) the output register loads in_data[g], in_last[g], out_id = g, and out_valid <= 1.
  - When out_valid & out_ready and no new transfer occurs, out_valid <= 0.
  - If `in_valid[g]` drops mid-packet, remain in BUSY and wait; other requesters are not served.
  - When the transferred beat has `in_last` = 1, go to IDLE on the same edge.
- **Fairness:** requests are sampled only in IDLE. A requester that asserts while another packet is in flight is served after at most NUM_INPUTS-1 other packets.
- **Single-beat packets:** a beat with `in_last` = 1 on its first beat is legal. BUSY lasts as long as it takes to accept that one beat.
- **Reset:** `areset` high at any edge, including mid-packet, has the following effects:
  - State goes to IDLE and p <= NUM_INPUTS-1.
  - out_valid, out_last and out_id are set to 0; all `in_ready` are 0 during and after reset until the next grant.
  - Any partial packet is abandoned; no recovery is attempted.
  - `out_data` is not reset and is don't-care while out_valid = 0.

## Timing
- **Arbitration latency:** with IDLE in cycle t and a request present, BUSY starts at t+1, and `in_ready[g]` can be high in t+1.
- **Data latency:** a beat accepted at edge e appears with out_valid = 1 after e, i.e. one cycle later.
- **Throughput inside a packet:** 1 beat per cycle while out_ready = 1.
- **Backpressure:** with out_valid = 1 and out_ready = 0, `in_ready[g]` = 0. The output register then holds data, last and id stable until accepted.
- **Inter-packet gap:** after the `in_last` beat is accepted at edge e, the cycle after e is IDLE with no `in_ready`. The next packet's first beat can be accepted at the end of the following cycle, giving exactly one bubble on the output.
- **Simultaneous requests in IDLE:** resolved purely by pointer order, not by arrival time.
- `in_valid` must not depend on `in_ready`, per AXI4-Stream.

## Test plan
- **Reset values:** hold `areset` 3 cycles with all inputs valid. Required: `in_ready` = 0, out_valid = 0, out_id = 0 throughout. On the first IDLE cycle after reset, input 0 is granted.
- **Round robin, simultaneous 2-beat packets:** NUM_INPUTS = 4; all inputs continuously offer 2-beat packets with out_ready = 1. Required:
  - out_id sequence is 0,0,1,1,2,2,3,3,0,0,….
  - Exactly one idle output cycle after each `out_last`.
  - No interleaving.
- **Backpressure:** input 2 sends beats 0xA0, 0xA1, 0xA2 (last); out_ready toggles 1,0,0,1,…. Required:
  - Output carries 0xA0, 0xA1, 0xA2 in order with out_id = 2.
  - out_data is stable while stalled.
  - `in_ready[2]` is low whenever out_valid & ~out_ready.
- **Source stall:** input 1 drops `in_valid` for 5 cycles mid-packet while input 3 is requesting. Required:
  - Grant stays on 1 and `in_ready[3]` = 0 during the stall.
  - Input 3 is served only after input 1's last beat.
- **Single-beat packets:** inputs 0 and 3 send one-beat packets repeatedly with out_ready = 1. Required: out_id alternates 0,3,0,3 with out_last = 1 on every beat, at one beat per two cycles.
- **Reset mid-packet:** assert `areset` for one cycle during beat 2 of a 4-beat packet from input 1. Required:
  - out_valid = 0 on the next cycle.
  - The next grant follows reset priority, with input 0 first if it is requesting.
